// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one shared combinational ALU: round-robin grant,
// operand capture, one execute cycle, then a held result until the owner takes it.
module alu_share_ctrl #(
  parameter int word_size = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [2:0]           req0_op,
  input  logic [word_size-1:0] req0_a,
  input  logic [word_size-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [2:0]           req1_op,
  input  logic [word_size-1:0] req1_a,
  input  logic [word_size-1:0] req1_b,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [word_size-1:0] rsp_data,
  output logic                 rsp_err,
  output logic [word_size-1:0] alu_R2,
  output logic [word_size-1:0] alu_R3,
  output logic [2:0]           alu_ALUOp,
  input  logic [word_size-1:0] alu_R1,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;
  logic [2:0]           op_q, op_d;
  logic [word_size-1:0] a_q, a_d;
  logic [word_size-1:0] b_q, b_d;
  logic [word_size-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 winner;
  logic [2:0]           sel_op;
  logic                 owner_rsp_ready;

  // Round-robin grant: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_q;
    end else if (req1_valid) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

  // Next-state and handshake logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_d          = last_q;
    err_d           = err_q;
    op_d            = op_q;
    a_d             = a_q;
    b_d             = b_q;
    rsp_data_d      = rsp_data_q;
    rsp_err_d       = rsp_err_q;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;
    sel_op          = winner ? req1_op : req0_op;
    owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
    case (state_q)
      IDLE: begin
        // Ready is held low during reset so nothing is accepted and then dropped.
        if (!rst && (req0_valid || req1_valid)) begin
          req0_ready = ~winner;
          req1_ready = winner;
          owner_d    = winner;
          a_d        = winner ? req1_a : req0_a;
          b_d        = winner ? req1_b : req0_b;
          if (sel_op == 3'd7) begin
            op_d  = 3'd0;
            err_d = 1'b1;
          end else begin
            op_d  = sel_op;
            err_d = 1'b0;
          end
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_data_d = err_q ? '0 : alu_R1;
        rsp_err_d  = err_q;
        state_d    = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          last_d  = owner_q;
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      err_q      <= 1'b0;
      op_q       <= 3'd0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      err_q      <= err_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // The ALU only ever sees captured operands, so an illegal op never reaches it.
  assign alu_R2     = a_q;
  assign alu_R3     = b_q;
  assign alu_ALUOp  = op_q;
  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) && owner_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE);

endmodule
